// File: rtl/sindoku_pkg.sv
// Shared constants, state encoding and puzzle-definition helpers for the Sudoku game core.
package sindoku_pkg;

  localparam int N       = 9;
  localparam int DIGIT_W = 5;

  typedef enum logic [2:0] {I, SOLVE, CHECK, CORRECT, INCORRECT} state_t;

  // Solution is a shifted Latin pattern: band offset plus row-in-band shift of three.
  function automatic logic [3:0] sol(input logic [3:0] r, input logic [3:0] c);
    logic [4:0] sum;
    sum = 5'(3 * (r % 3)) + 5'(r / 3) + 5'(c);
    return 4'((sum % 9) + 1);
  endfunction

  function automatic logic is_given(input logic [3:0] r, input logic [3:0] c);
    logic [4:0] sum;
    sum = 5'(r) + 5'(c);
    return (sum[1:0] == 2'd0);
  endfunction

  // Bit order matches {q_I, q_Solve, q_Check, q_Correct, q_Incorrect}.
  function automatic logic [4:0] onehot(input state_t s);
    logic [4:0] v;
    v = 5'b00000;
    case (s)
      I:         v = 5'b10000;
      SOLVE:     v = 5'b01000;
      CHECK:     v = 5'b00100;
      CORRECT:   v = 5'b00010;
      INCORRECT: v = 5'b00001;
      default:   v = 5'b10000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sindoku_board.sv
// 9x9 cell store: parallel reload of the givens, guarded single write, two async read ports.
module sindoku_board
  import sindoku_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_load,
  input  logic               i_we,
  input  logic [3:0]         i_wrRow,
  input  logic [3:0]         i_wrCol,
  input  logic [DIGIT_W-1:0] i_wrData,
  input  logic [3:0]         i_rdRow,
  input  logic [3:0]         i_rdCol,
  input  logic [3:0]         i_dispRow,
  input  logic [3:0]         i_dispCol,
  output logic [DIGIT_W-1:0] o_rdData,
  output logic [DIGIT_W-1:0] o_dispData
);

  logic [3:0] r_cells [N][N];
  logic       w_writeOk;

  // Givens are write-protected and only 0..9 may be stored.
  assign w_writeOk = i_we && !is_given(i_wrRow, i_wrCol) && (i_wrData <= 5'd9);

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_cells[r][c] <= is_given(4'(r), 4'(c)) ? sol(4'(r), 4'(c)) : 4'd0;
        end
      end
    end else if (w_writeOk) begin
      r_cells[i_wrRow][i_wrCol] <= i_wrData[3:0];
    end
  end

  assign o_rdData   = {1'b0, r_cells[i_rdRow][i_rdCol]};
  assign o_dispData = {1'b0, r_cells[i_dispRow][i_dispCol]};

endmodule

// File: rtl/sindoku_game.sv
// Sudoku game controller: cursor/entry handling, cell-by-cell solution check and display scan.
module sindoku_game
  import sindoku_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_R,
  input  logic               i_L,
  input  logic               i_U,
  input  logic               i_D,
  input  logic               i_C,
  input  logic               i_Ack,
  input  logic               i_CheckSolu,
  input  logic [DIGIT_W-1:0] i_userIn,
  output logic               o_q_I,
  output logic               o_q_Solve,
  output logic               o_q_Check,
  output logic               o_q_Correct,
  output logic               o_q_Incorrect,
  output logic [3:0]         o_row,
  output logic [3:0]         o_col,
  output logic [4:0]         o_i,
  output logic [4:0]         o_j,
  output logic [DIGIT_W-1:0] o_puzzle_ij,
  output logic [DIGIT_W-1:0] o_solu_ij,
  output logic [4:0]         o_disp_i,
  output logic [4:0]         o_disp_j,
  output logic [DIGIT_W-1:0] o_disp_value
);

  state_t     r_state;
  logic [4:0] r_onehot;
  logic [3:0] r_row, r_col, r_i, r_j, r_dispI, r_dispJ;
  logic       w_load, w_we, w_match;
  logic [DIGIT_W-1:0] w_puzzle, w_disp;

  function automatic logic [3:0] incWrap(input logic [3:0] v);
    return (v == 4'(N - 1)) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] decWrap(input logic [3:0] v);
    return (v == 4'd0) ? 4'(N - 1) : v - 4'd1;
  endfunction

  // Reset also reloads so the board is never undefined while sitting in I.
  assign w_load  = i_Reset || (r_state == I);
  assign w_we    = (r_state == SOLVE) && !i_CheckSolu && i_C;
  assign w_match = (w_puzzle == {1'b0, sol(r_i, r_j)});

  sindoku_board u_board (
    .i_clk      (i_Clk),
    .i_load     (w_load),
    .i_we       (w_we),
    .i_wrRow    (r_row),
    .i_wrCol    (r_col),
    .i_wrData   (i_userIn),
    .i_rdRow    (r_i),
    .i_rdCol    (r_j),
    .i_dispRow  (r_dispI),
    .i_dispCol  (r_dispJ),
    .o_rdData   (w_puzzle),
    .o_dispData (w_disp)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state  <= I;
      r_onehot <= onehot(I);
      r_row    <= 4'd0;
      r_col    <= 4'd0;
      r_i      <= 4'd0;
      r_j      <= 4'd0;
    end else begin
      case (r_state)
        I: begin
          r_row    <= 4'd0;
          r_col    <= 4'd0;
          r_i      <= 4'd0;
          r_j      <= 4'd0;
          r_state  <= SOLVE;
          r_onehot <= onehot(SOLVE);
        end
        SOLVE: begin
          if (i_CheckSolu) begin
            r_i      <= 4'd0;
            r_j      <= 4'd0;
            r_state  <= CHECK;
            r_onehot <= onehot(CHECK);
          end else if (!i_C) begin
            if (i_R)      r_col <= incWrap(r_col);
            else if (i_L) r_col <= decWrap(r_col);
            else if (i_U) r_row <= decWrap(r_row);
            else if (i_D) r_row <= incWrap(r_row);
          end
        end
        CHECK: begin
          if (!w_match) begin
            r_state  <= INCORRECT;
            r_onehot <= onehot(INCORRECT);
          end else if (r_i == 4'(N - 1) && r_j == 4'(N - 1)) begin
            r_state  <= CORRECT;
            r_onehot <= onehot(CORRECT);
          end else if (r_j == 4'(N - 1)) begin
            r_j <= 4'd0;
            r_i <= r_i + 4'd1;
          end else begin
            r_j <= r_j + 4'd1;
          end
        end
        CORRECT, INCORRECT: begin
          if (i_Ack) begin
            r_state  <= I;
            r_onehot <= onehot(I);
          end
        end
        default: begin
          r_state  <= I;
          r_onehot <= onehot(I);
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_dispI <= 4'd0;
      r_dispJ <= 4'd0;
    end else if (r_dispJ == 4'(N - 1)) begin
      r_dispJ <= 4'd0;
      r_dispI <= incWrap(r_dispI);
    end else begin
      r_dispJ <= r_dispJ + 4'd1;
    end
  end

  assign {o_q_I, o_q_Solve, o_q_Check, o_q_Correct, o_q_Incorrect} = r_onehot;
  assign o_row        = r_row;
  assign o_col        = r_col;
  assign o_i          = {1'b0, r_i};
  assign o_j          = {1'b0, r_j};
  assign o_puzzle_ij  = w_puzzle;
  assign o_solu_ij    = {1'b0, sol(r_i, r_j)};
  assign o_disp_i     = {1'b0, r_dispI};
  assign o_disp_j     = {1'b0, r_dispJ};
  assign o_disp_value = w_disp;

endmodule

// File: tb/tb_sindoku_game.sv
// Self-checking bench for sindoku_game: vector table, directed corner sequences, random walk vs model.
module tb_sindoku_game;

  logic       clk = 1'b0;
  logic       rst = 1'b0, bR = 1'b0, bL = 1'b0, bU = 1'b0, bD = 1'b0;
  logic       bC = 1'b0, bAck = 1'b0, bChk = 1'b0;
  logic [4:0] userIn = 5'd0;
  logic       qI, qSolve, qCheck, qCorrect, qIncorrect;
  logic [3:0] row, col;
  logic [4:0] oi, oj, puzzleIj, soluIj, dispI, dispJ, dispValue;

  always #5 clk = ~clk;

  sindoku_game dut (
    .i_Clk(clk), .i_Reset(rst), .i_R(bR), .i_L(bL), .i_U(bU), .i_D(bD),
    .i_C(bC), .i_Ack(bAck), .i_CheckSolu(bChk), .i_userIn(userIn),
    .o_q_I(qI), .o_q_Solve(qSolve), .o_q_Check(qCheck), .o_q_Correct(qCorrect),
    .o_q_Incorrect(qIncorrect), .o_row(row), .o_col(col), .o_i(oi), .o_j(oj),
    .o_puzzle_ij(puzzleIj), .o_solu_ij(soluIj), .o_disp_i(dispI), .o_disp_j(dispJ),
    .o_disp_value(dispValue)
  );

  typedef struct packed {
    bit rst, r, l, u, d, c, ack, chk;
    logic [4:0] userIn;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [4:0] expState;
    int         expRow;
    int         expCol;
  } vec_t;

  localparam logic [4:0] OH_I = 5'b10000, OH_S = 5'b01000, OH_CK = 5'b00100;
  localparam logic [4:0] OH_OK = 5'b00010, OH_BAD = 5'b00001;
  localparam int M_I = 0, M_SOLVE = 1, M_CHECK = 2, M_CORRECT = 3, M_INCORRECT = 4;

  // Reference model: board as plain ints, check progress as a linear cell index.
  int mState = M_I, mRow = 0, mCol = 0, mK = 0, mDisp = 0;
  int mBoard [9][9];
  int total = 0, bad = 0;

  function automatic int refSol(int r, int c);
    return ((3 * (r % 3) + r / 3 + c) % 9) + 1;
  endfunction

  function automatic bit refGiven(int r, int c);
    return ((r + c) % 4) == 0;
  endfunction

  function automatic void modelLoad();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        mBoard[r][c] = refGiven(r, c) ? refSol(r, c) : 0;
  endfunction

  function automatic void modelStep(stim_t s);
    if (s.rst) begin
      mState = M_I; mRow = 0; mCol = 0; mK = 0; mDisp = 0;
      modelLoad();
      return;
    end
    mDisp = (mDisp + 1) % 81;
    case (mState)
      M_I: begin
        modelLoad();
        mRow = 0; mCol = 0; mK = 0; mState = M_SOLVE;
      end
      M_SOLVE: begin
        if (s.chk) begin
          mK = 0; mState = M_CHECK;
        end else if (s.c) begin
          if (!refGiven(mRow, mCol) && int'(s.userIn) <= 9) mBoard[mRow][mCol] = int'(s.userIn);
        end else if (s.r) mCol = (mCol + 1) % 9;
        else if (s.l) mCol = (mCol + 8) % 9;
        else if (s.u) mRow = (mRow + 8) % 9;
        else if (s.d) mRow = (mRow + 1) % 9;
      end
      M_CHECK: begin
        if (mBoard[mK / 9][mK % 9] != refSol(mK / 9, mK % 9)) mState = M_INCORRECT;
        else if (mK == 80) mState = M_CORRECT;
        else mK++;
      end
      default: if (s.ack) mState = M_I;
    endcase
  endfunction

  function automatic stim_t mk(bit r0, bit r, bit l, bit u, bit d, bit c, bit ack, bit chk,
                               logic [4:0] v);
    stim_t s;
    s.rst = r0; s.r = r; s.l = l; s.u = u; s.d = d; s.c = c; s.ack = ack; s.chk = chk;
    s.userIn = v;
    return s;
  endfunction

  task automatic compare(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic checkOutput();
    compare("state", int'({qI, qSolve, qCheck, qCorrect, qIncorrect}), int'(5'b10000 >> mState));
    compare("row", int'(row), mRow);
    compare("col", int'(col), mCol);
    compare("i", int'(oi), mK / 9);
    compare("j", int'(oj), mK % 9);
    compare("puzzle_ij", int'(puzzleIj), mBoard[mK / 9][mK % 9]);
    compare("solu_ij", int'(soluIj), refSol(mK / 9, mK % 9));
    compare("disp_i", int'(dispI), mDisp / 9);
    compare("disp_j", int'(dispJ), mDisp % 9);
    compare("disp_value", int'(dispValue), mBoard[mDisp / 9][mDisp % 9]);
  endtask

  task automatic applyStimulus(input stim_t s);
    {rst, bR, bL, bU, bD, bC, bAck, bChk} = {s.rst, s.r, s.l, s.u, s.d, s.c, s.ack, s.chk};
    userIn = s.userIn;
    @(posedge clk);
    modelStep(s);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus('0);
  endtask

  // Waits (bounded) for the display scan to reach (r,c) and checks the shown value.
  task automatic readCell(input string name, input int r, input int c, input int expected);
    for (int n = 0; n < 90; n++) begin
      if (int'(dispI) == r && int'(dispJ) == c) begin
        compare(name, int'(dispValue), expected);
        return;
      end
      idle();
    end
    compare({name, "_timeout"}, -1, expected);
  endtask

  task automatic fillSolution();
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        if (!refGiven(r, c)) applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'(refSol(r, c))));
        if (c < 8) applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd0));
      end
      applyStimulus(mk(0, 0, 0, 0, 1, 0, 0, 0, 5'd0));
      applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd0));
    end
  endtask

  vec_t vecs [17];
  bit   seen [81];

  initial begin
    int cyc, nSeen;
    stim_t s;

    vecs[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 5'd0), OH_I, 0, 0};
    vecs[1]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 5'd0), OH_S, 0, 0};
    vecs[2]  = '{mk(0, 0, 1, 0, 0, 0, 0, 0, 5'd0), OH_S, 0, 8};
    vecs[3]  = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd0), OH_S, 0, 0};
    vecs[4]  = '{mk(0, 0, 0, 1, 0, 0, 0, 0, 5'd0), OH_S, 8, 0};
    vecs[5]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 5'd0), OH_S, 0, 0};
    vecs[6]  = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd0), OH_S, 0, 1};
    vecs[7]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 5'd2), OH_S, 0, 1};
    vecs[8]  = '{mk(0, 1, 0, 0, 0, 1, 0, 0, 5'd3), OH_S, 0, 1};
    vecs[9]  = '{mk(0, 0, 1, 1, 0, 0, 0, 0, 5'd0), OH_S, 0, 0};
    vecs[10] = '{mk(0, 0, 0, 1, 1, 0, 0, 0, 5'd0), OH_S, 8, 0};
    vecs[11] = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 5'd0), OH_S, 0, 0};
    vecs[12] = '{mk(0, 1, 0, 0, 0, 0, 0, 1, 5'd0), OH_CK, 0, 0};
    vecs[13] = '{mk(0, 1, 0, 0, 0, 1, 0, 0, 5'd4), OH_CK, 0, 0};
    vecs[14] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 5'd0), OH_BAD, 0, 0};
    vecs[15] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 5'd0), OH_I, 0, 0};
    vecs[16] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 5'd0), OH_S, 0, 0};

    for (int n = 0; n < 17; n++) begin
      applyStimulus(vecs[n].s);
      compare($sformatf("vec%0d_state", n), int'({qI, qSolve, qCheck, qCorrect, qIncorrect}),
              int'(vecs[n].expState));
      compare($sformatf("vec%0d_row", n), int'(row), vecs[n].expRow);
      compare($sformatf("vec%0d_col", n), int'(col), vecs[n].expCol);
    end

    // Fresh board contents and the entry rules.
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    idle();
    readCell("given00", 0, 0, 1);
    readCell("given04", 0, 4, 5);
    readCell("blank01", 0, 1, 0);
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd0));
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'd2));
    readCell("write2", 0, 1, 2);
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'd0));
    readCell("clear0", 0, 1, 0);
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 5'd0));
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'd7));
    readCell("givenProtect", 0, 0, 1);
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd0));
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'd12));
    readCell("rejectOver9", 0, 1, 0);

    // Incorrect path with a stray entry that the reload must clear.
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    idle();
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd0));
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd0));
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'd7));
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 5'd0));
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 5'd0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd0));
    compare("incEnterCheck", int'(qCheck), 1);
    idle();
    compare("incStillCheck_j", int'(oj), 1);
    idle();
    compare("incState", int'(qIncorrect), 1);
    compare("incI", int'(oi), 0);
    compare("incJ", int'(oj), 1);
    compare("incPuzzle", int'(puzzleIj), 0);
    compare("incSolu", int'(soluIj), 2);
    idle();
    compare("incHold", int'(qIncorrect), 1);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'd0));
    compare("incAckToI", int'(qI), 1);
    idle();
    compare("incBackSolve", int'(qSolve), 1);
    readCell("incReloaded", 0, 2, 0);

    // Reset in the middle of a check of a correct board.
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    idle();
    fillSolution();
    compare("fillCursorRow", int'(row), 0);
    compare("fillCursorCol", int'(col), 0);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd0));
    for (int n = 1; n < 40; n++) idle();
    compare("midCheckState", int'(qCheck), 1);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    compare("midResetI", int'(qI), 1);
    compare("midResetIdx", int'({oi, oj}), 0);
    idle();
    readCell("midReloaded", 0, 1, 0);

    // Full correct board: exactly 81 cycles in check.
    fillSolution();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd0));
    cyc = 0;
    while (qCheck && cyc < 200) begin
      cyc++;
      idle();
    end
    compare("checkCycles", cyc, 81);
    compare("correctState", int'(qCorrect), 1);
    compare("correctIdx", int'({oi, oj}), int'({5'd8, 5'd8}));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'd0));
    compare("correctAckToI", int'(qI), 1);

    // Display scan coverage over one frame.
    for (int n = 0; n < 81; n++) seen[n] = 1'b0;
    for (int n = 0; n < 81; n++) begin
      seen[int'(dispI) * 9 + int'(dispJ)] = 1'b1;
      idle();
    end
    nSeen = 0;
    for (int n = 0; n < 81; n++) nSeen += int'(seen[n]);
    compare("dispCoverage", nSeen, 81);

    // Random walk against the model.
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    for (int n = 0; n < 1500; n++) begin
      s = mk($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, 5'($urandom_range(0, 15)));
      applyStimulus(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sindoku_game.md
Name: sindoku_game

Overview:
- Core game controller for a 9x9 Sudoku played on the board with buttons.
- Holds the puzzle board, a cursor and a fixed solution; accepts digit entry at the cursor; on request checks the board cell by cell against the solution.
- Drives one-hot state outputs and a round-robin cell scan for the VGA renderer.
- Button inputs are single-cycle debounced pulses from the top level.

Parameters:
- None. Board size (9) and digit width (5) are package constants.

Ports:
Clk  in  1  system clock; all logic on rising edge
Reset  in  1  synchronous, active-high
R  in  1  move cursor right (pulse)
L  in  1  move cursor left (pulse)
U  in  1  move cursor up (pulse)
D  in  1  move cursor down (pulse)
C  in  1  write userIn into the cursor cell (pulse)
Ack  in  1  acknowledge result; leave q_Correct/q_Incorrect
CheckSolu  in  1  start solution check (pulse)
userIn  in  5  digit to enter; 0 clears the cell; 1..9 valid
q_I, q_Solve, q_Check, q_Correct, q_Incorrect  out  1 each  one-hot state
row  out  4  cursor row, 0..8
col  out  4  cursor column, 0..8
i  out  5  check-scan row, 0..8
j  out  5  check-scan column, 0..8
puzzle_ij  out  5  board value at (i,j)
solu_ij  out  5  solution value at (i,j)
disp_i  out  5  display-scan row
disp_j  out  5  display-scan column
disp_value  out  5  board value at (disp_i,disp_j); 0 means blank

Behaviour:
- Solution: SOL(r,c) = ((3*(r mod 3) + r/3 + c) mod 9) + 1.
- Givens: cell is given iff (r+c) mod 4 == 0; its initial board value is SOL(r,c). All other cells start at 0.
- Reset: state q_I; row=col=i=j=0; disp_i=disp_j=0.
- q_I:
  - Loads all 81 cells in parallel from the given mask and SOL.
  - Resets the cursor to (0,0) and i=j=0.
  - Moves unconditionally to q_Solve on the next edge. Inputs are ignored while in q_I.
- q_Solve:
  - Exactly one event is acted on per clock. Priority: CheckSolu > C > R > L > U > D.
  - R/L change col by +1/-1; U/D change row by -1/+1. Movement wraps: col 8 +R goes to 0; col 0 +L goes to 8; rows likewise.
  - C writes userIn to board[row][col] only if the cell is not given and userIn <= 9. Otherwise the board is unchanged.
  - The written value is visible on the board the next cycle.
  - CheckSolu: set i=j=0, go to q_Check.
- q_Check:
  - Each cycle compare board[i][j] with SOL(i,j).
  - Mismatch: go to q_Incorrect; i,j hold the failing cell.
  - Match at (8,8): go to q_Correct.
  - Otherwise advance j; at j=8, wrap j to 0 and increment i.
  - All buttons are ignored. A fully correct board spends 81 cycles in q_Check.
- q_Correct / q_Incorrect:
  - Hold until Ack=1, then go to q_I (board reloaded).
  - Board, cursor and i/j are frozen in these states.
- puzzle_ij and solu_ij are combinational from (i,j) in every state.
- Display scan runs every clock in every state except during Reset:
  - disp_j increments; at 8 it wraps to 0 and disp_i increments; disp_i wraps 8 to 0.
  - disp_value is the combinational board read at (disp_i, disp_j).
- Reset in any state, including mid-check, returns to q_I on the next edge.
- Outputs i/j/row/col are zero-extended to port width.

Decomposition:
- Package sindoku_pkg:
  - state enum: I, SOLVE, CHECK, CORRECT, INCORRECT
  - N=9, DIGIT_W=5
  - functions sol(r,c) and is_given(r,c)
- Sub-module sindoku_board:
  - 81x4-bit cell array
  - parallel load
  - guarded write port
  - two combinational read ports (check and display)
- FSM, cursor and scan counters live in the top module.

Test Plan:
- Reset, then 2 clocks -> q_I for one cycle then q_Solve; row=0, col=0; board(0,0)=1, (0,4)=5, (0,1)=0.
- Cursor wrap: L at (0,0) -> col=8; R -> col=0; U -> row=8; D -> row=0. R and C pulsed together -> write only, cursor unchanged.
- Entry rules:
  - At (0,1), userIn=2, C -> cell=2.
  - userIn=0, C -> cell=0.
  - At (0,0), userIn=7, C -> cell stays 1 (given).
  - userIn=12, C at (0,1) -> unchanged.
- Incorrect: fresh board, CheckSolu -> q_Check with (0,0) matching, then (0,1) mismatches. q_Incorrect asserted 2 cycles after q_Check entry with i=0, j=1, puzzle_ij=0, solu_ij=2. Ack -> q_I -> q_Solve with board reloaded.
- Correct: fill every blank with SOL via cursor moves and C, then CheckSolu -> q_Correct after exactly 81 cycles in q_Check. Ack returns to q_I.
- Reset asserted at check cycle 40 -> q_I next edge; i=j=0; board reloaded. Display scan visits all 81 cells every 81 clocks with disp_value matching the board.
